lsu_misaligned: RTL and testbench

- Load/store unit directly downstream of the integer ALU. It consumes the ALU result as the effective address.
- Drives a word-wide synchronous data memory with byte strobes. Any halfword/word access that crosses a 32-bit word boundary is split into two word accesses.
- Load bytes are merged, then sign- or zero-extended before return to writeback.
- Valid/ready request in, one-cycle response pulse out.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/lsu_misaligned.sv | 128 ++++++++++++
 tb/tb_lsu_misaligned.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 encodings, FSM state type and access-size decode
//               for the misaligned-capable load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Illegal encodings fall to 4 bytes; they never reach memory anyway.
    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_bytes = 3'd1;
            F3_H, F3_HU: access_bytes = 3'd2;
            default:     access_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane steering: store data/strobes spread over
//               two words, and load field extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [63:0] combined,
    output logic [63:0] wide,
    output logic [7:0]  mask8,
    output logic [31:0] load_data
);

    logic [2:0]  w_nbytes;
    logic [7:0]  w_ones;
    logic [31:0] w_field;

    assign w_nbytes = access_bytes(funct3);

    always_comb begin
        w_ones = 8'h0F;
        case (w_nbytes)
            3'd1:    w_ones = 8'h01;
            3'd2:    w_ones = 8'h03;
            default: w_ones = 8'h0F;
        endcase
    end

    // Bytes spilling past lane 3 land in the upper word of the 64-bit window.
    assign mask8 = w_ones << off;
    assign wide  = {32'b0, wdata} << {off, 3'b000};

    assign w_field = 32'(combined >> {off, 3'b000});

    always_comb begin
        load_data = 32'b0;
        case (funct3)
            F3_B:    load_data = {{24{w_field[7]}}, w_field[7:0]};
            F3_H:    load_data = {{16{w_field[15]}}, w_field[15:0]};
            F3_W:    load_data = w_field;
            F3_BU:   load_data = {24'b0, w_field[7:0]};
            F3_HU:   load_data = {16'b0, w_field[15:0]};
            default: load_data = 32'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_misaligned.sv
`default_nettype none
// ============================================================================
// Module      : lsu_misaligned
// Description : Load/store unit that splits word-boundary-crossing accesses into
//               two word accesses on a synchronous byte-strobed data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_misaligned
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    lsu_state_t  r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_lo;

    logic [2:0]  w_req_n;
    logic        w_req_cross;
    logic        w_req_f3_ok;
    logic        w_req_illegal;
    logic [2:0]  w_n;
    logic        w_cross;
    logic        w_access;
    logic [63:0] w_wide;
    logic [7:0]  w_mask8;
    logic [63:0] w_combined;
    logic [31:0] w_load_data;

    // Legality is judged on the live request so an illegal one skips memory.
    assign w_req_n     = access_bytes(req_funct3);
    assign w_req_cross = ({2'b00, req_addr[1:0]} + {1'b0, w_req_n}) > 4'd4;

    always_comb begin
        w_req_f3_ok = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: w_req_f3_ok = 1'b1;
            F3_BU, F3_HU:     w_req_f3_ok = !req_store;
            default:          w_req_f3_ok = 1'b0;
        endcase
    end

    assign w_req_illegal = !w_req_f3_ok || (w_req_cross && !MISALIGN_EN);

    assign w_n     = access_bytes(r_funct3);
    assign w_cross = ({2'b00, r_addr[1:0]} + {1'b0, w_n}) > 4'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b0;
            r_addr   <= 32'b0;
            r_wdata  <= 32'b0;
            r_err    <= 1'b0;
            r_lo     <= 32'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_err    <= w_req_illegal;
                        r_state  <= w_req_illegal ? RESP : FIRST;
                    end
                end
                FIRST:   r_state <= w_cross ? SECOND : RESP;
                SECOND: begin
                    r_lo    <= mem_rdata;
                    r_state <= RESP;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_combined = w_cross ? {mem_rdata, r_lo} : {32'b0, mem_rdata};

    lsu_lane_align u_lane_align (
        .wdata     (r_wdata),
        .off       (r_addr[1:0]),
        .funct3    (r_funct3),
        .combined  (w_combined),
        .wide      (w_wide),
        .mask8     (w_mask8),
        .load_data (w_load_data)
    );

    // Memory strobes are squashed during reset so an interrupted split store
    // cannot write in the reset cycle.
    assign w_access  = (r_state == FIRST) || (r_state == SECOND);
    assign mem_en    = w_access && !reset;
    assign mem_addr  = (r_state == SECOND) ? (r_addr[31:2] + 30'd1) : r_addr[31:2];
    assign mem_we    = (mem_en && r_store) ?
                       ((r_state == SECOND) ? w_mask8[7:4] : w_mask8[3:0]) : 4'b0;
    assign mem_wdata = (r_state == SECOND) ? w_wide[63:32] : w_wide[31:0];

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP) && !reset;
    assign resp_err   = resp_valid && r_err;
    assign resp_data  = (resp_valid && !r_store && !r_err) ? w_load_data : 32'b0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_misaligned.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_misaligned
// Description : Self-checking bench: directed cases plus random traffic against
//               a byte-addressed reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_misaligned;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid0, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, mem_en, resp_valid, resp_err;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata, mem_rdata, resp_data;

    logic        req_ready0, mem_en0, resp_valid0, resp_err0;
    logic [29:0] mem_addr0;
    logic [3:0]  mem_we0;
    logic [31:0] mem_wdata0, resp_data0;
    logic [31:0] mem_rdata0 = 32'hCAFEF00D;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_misaligned #(.MISALIGN_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    lsu_misaligned #(.MISALIGN_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_we(mem_we0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .resp_valid(resp_valid0),
        .resp_data(resp_data0), .resp_err(resp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word memory driven by the DUT, and an independent byte-level reference.
    logic [31:0] tb_mem  [logic [29:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] mw;

    function automatic logic [31:0] dflt_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] rd_word(input logic [29:0] wa);
        return tb_mem.exists(wa) ? tb_mem[wa] : dflt_word(wa);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] b);
        logic [31:0] w;
        if (ref_mem.exists(b)) return ref_mem[b];
        w = dflt_word(b[31:2]);
        return w[8*b[1:0] +: 8];
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'b0) begin
                mw = rd_word(mem_addr);
                for (int i = 0; i < 4; i++)
                    if (mem_we[i]) mw[8*i +: 8] = mem_wdata[8*i +: 8];
                tb_mem[mem_addr] = mw;
            end else begin
                mem_rdata <= rd_word(mem_addr);
            end
        end
    end

    task automatic preload(input logic [29:0] wa, input logic [31:0] val);
        tb_mem[wa] = val;
        for (int i = 0; i < 4; i++) ref_mem[{wa, 2'b00} + 32'(i)] = val[8*i +: 8];
    endtask

    logic [29:0] acc_addr [4];
    logic [3:0]  acc_we   [4];
    logic [31:0] acc_wd   [4];
    int          n_acc;
    int          lat;
    logic [31:0] got_data;

    task automatic run_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        int          n, ne, exp_lat, lane;
        bit          legal;
        logic [31:0] exp_data, b, lmask;
        logic [29:0] ewa [2];
        logic [3:0]  ewe [2];
        logic [31:0] ewd [2];
        logic        gerr;

        n     = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        legal = st ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        ne = 0;
        exp_data = 32'b0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                b = a + 32'(i);
                lane = int'(b[1:0]);
                if (ne == 0 || ewa[ne-1] != b[31:2]) begin
                    ewa[ne] = b[31:2];
                    ewe[ne] = 4'b0;
                    ewd[ne] = 32'b0;
                    ne++;
                end
                if (st) begin
                    ewe[ne-1][lane] = 1'b1;
                    ewd[ne-1][8*lane +: 8] = wd[8*i +: 8];
                end else begin
                    exp_data[8*i +: 8] = ref_rd(b);
                end
            end
            if (!st && f3 == 3'b000) exp_data = {{24{exp_data[7]}}, exp_data[7:0]};
            if (!st && f3 == 3'b001) exp_data = {{16{exp_data[15]}}, exp_data[15:0]};
        end
        exp_lat = !legal ? 1 : (ne == 2 ? 3 : 2);

        @(negedge clk);
        chk("ready", {31'b0, req_ready}, 32'd1);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        n_acc = 0; lat = 0; got_data = 32'b0; gerr = 1'b0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_en) begin
                if (n_acc < 4) begin
                    acc_addr[n_acc] = mem_addr;
                    acc_we[n_acc]   = mem_we;
                    acc_wd[n_acc]   = mem_wdata;
                end
                n_acc++;
            end
            if (resp_valid) begin
                lat = k;
                got_data = resp_data;
                gerr = resp_err;
            end
        end

        chk("latency", 32'(lat), 32'(exp_lat));
        chk("n_access", 32'(n_acc), 32'(ne));
        for (int k = 0; k < ne && k < n_acc; k++) begin
            chk("acc_addr", {2'b00, acc_addr[k]}, {2'b00, ewa[k]});
            chk("acc_we", {28'b0, acc_we[k]}, {28'b0, ewe[k]});
            for (int j = 0; j < 4; j++) lmask[8*j +: 8] = {8{ewe[k][j]}};
            chk("acc_wdata", acc_wd[k] & lmask, ewd[k]);
        end
        chk("resp_err", {31'b0, gerr}, {31'b0, !legal});
        if (legal) chk("resp_data", got_data, st ? 32'b0 : exp_data);

        if (legal && st)
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic run_req0(input logic [2:0] f3, input logic [31:0] a,
                            input logic exp_err, input int exp_lat, input logic [31:0] exp_data);
        int   n0, l0;
        logic e0;
        logic [31:0] d0;
        @(negedge clk);
        req_store = 1'b0; req_funct3 = f3; req_addr = a; req_wdata = 32'b0; req_valid0 = 1'b1;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        n0 = 0; l0 = 0; e0 = 1'b0; d0 = 32'b0;
        for (int k = 1; k <= 8 && l0 == 0; k++) begin
            @(negedge clk);
            if (mem_en0) n0++;
            if (resp_valid0) begin
                l0 = k; e0 = resp_err0; d0 = resp_data0;
            end
        end
        chk("m0_latency", 32'(l0), 32'(exp_lat));
        chk("m0_n_access", 32'(n0), exp_err ? 32'd0 : 32'd1);
        chk("m0_err", {31'b0, e0}, {31'b0, exp_err});
        if (!exp_err) chk("m0_data", d0, exp_data);
    endtask

    logic [31:0] pre81, pre82;
    logic        rs;
    logic [2:0]  rf;
    logic [31:0] ra;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        preload(30'h40, 32'h8899AABB);
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_lit", got_data, 32'h8899AABB);

        preload(30'h40, 32'h11223344);
        preload(30'h41, 32'h556677F2);
        run_req(1'b0, 3'b001, 32'h103, 32'h0);
        chk("lh_lit", got_data, 32'hFFFFF211);
        chk("lh_lat", 32'(lat), 32'd3);
        run_req(1'b0, 3'b101, 32'h103, 32'h0);
        chk("lhu_lit", got_data, 32'h0000F211);

        run_req(1'b1, 3'b010, 32'h206, 32'hDEADBEEF);
        chk("sw_a0", {2'b00, acc_addr[0]}, 32'h81);
        chk("sw_we0", {28'b0, acc_we[0]}, 32'hC);
        chk("sw_wd0", acc_wd[0], 32'hBEEF0000);
        chk("sw_a1", {2'b00, acc_addr[1]}, 32'h82);
        chk("sw_we1", {28'b0, acc_we[1]}, 32'h3);
        chk("sw_wd1", acc_wd[1], 32'h0000DEAD);
        run_req(1'b0, 3'b010, 32'h206, 32'h0);
        chk("sw_readback", got_data, 32'hDEADBEEF);

        run_req(1'b1, 3'b000, 32'h7, 32'h123);
        chk("sb_wd", acc_wd[0], 32'h23000000);
        chk("sb_we", {28'b0, acc_we[0]}, 32'h8);
        preload(30'h0, 32'h00800000);
        run_req(1'b0, 3'b000, 32'h2, 32'h0);
        chk("lb_lit", got_data, 32'hFFFFFF80);

        run_req(1'b0, 3'b011, 32'h100, 32'h0);
        run_req(1'b1, 3'b100, 32'h100, 32'h0);
        run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        chk("wrap_a1", {2'b00, acc_addr[1]}, 32'h0);

        run_req0(3'b010, 32'h1, 1'b1, 1, 32'h0);
        run_req0(3'b010, 32'h10, 1'b0, 2, 32'hCAFEF00D);
        run_req0(3'b001, 32'h2, 1'b0, 2, 32'hFFFFCAFE);
        run_req0(3'b001, 32'h3, 1'b1, 1, 32'h0);

        // Interrupt a split store in its first access cycle.
        pre81 = rd_word(30'h81);
        pre82 = rd_word(30'h82);
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h206;
        req_wdata = 32'h0BADCAFE; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_we", {28'b0, mem_we}, 32'd0);
        chk("midrst_en", {31'b0, mem_en}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("midrst_resp2", {31'b0, resp_valid}, 32'd0);
        chk("midrst_w81", rd_word(30'h81), pre81);
        chk("midrst_w82", rd_word(30'h82), pre82);

        for (int t = 0; t < 200; t++) begin
            rs = 1'($urandom);
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else                           ra = 32'h300 + 32'($urandom_range(0, 31));
            run_req(rs, rf, ra, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
